// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start/busy/done handshake plus data.
// Master is the issuing controller; slave is the subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_fs.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bo = borrow out.
// Zero latency; no flow control.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a registered borrow.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy (no queueing).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  import serial_sub_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  sub_state_t       state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_n;
  logic [CW-1:0]    cnt;
  logic             brw, a_msb, b_msb;
  logic             d, bo, last;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r, ovf_r;

  full_subtractor u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (brw),
    .d   (d),
    .bo  (bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  always_comb begin
    acc_n            = acc >> 1;
    acc_n[WIDTH-1]   = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            brw   <= 1'b0;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
          end
        end
        RUN: begin
          acc  <= acc_n;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= bo;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff_r <= acc_n;
            bout_r <= bo;
            // On the final bit d is the result sign; overflow iff operand signs differ
            // and the result sign differs from the minuend's.
            ovf_r  <= (a_msb ^ b_msb) & (d ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 4, 1 and 8 against an arithmetic model.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] want;
  } chk_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  int         wd[3] = '{4, 1, 8};
  logic       done_v[3];
  logic       busy_v[3];
  logic [7:0] diff_v[3];
  logic       bout_v[3];
  logic       ovf_v[3];

  assign done_v[0] = if4.done;  assign done_v[1] = if1.done;  assign done_v[2] = if8.done;
  assign busy_v[0] = if4.busy;  assign busy_v[1] = if1.busy;  assign busy_v[2] = if8.busy;
  assign diff_v[0] = {4'b0, if4.diff};
  assign diff_v[1] = {7'b0, if1.diff};
  assign diff_v[2] = if8.diff;
  assign bout_v[0] = if4.bout;  assign bout_v[1] = if1.bout;  assign bout_v[2] = if8.bout;
  assign ovf_v[0]  = if4.ovf;   assign ovf_v[1]  = if1.ovf;   assign ovf_v[2]  = if8.ovf;

  exp_t exp_q[3][$];
  chk_t chk_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   wait_cyc[3] = '{0, 0, 0};
  bit   end_req = 0;
  bit   end_ack = 0;
  int   acc_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands as unsigned and as two's complement.
  function automatic exp_t ref_sub(int w, logic [7:0] a, logic [7:0] b);
    exp_t r;
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int ua   = int'(a) & mask;
    int ub   = int'(b) & mask;
    int sa   = (ua >= half) ? ua - 2 * half : ua;
    int sb   = (ub >= half) ? ub - 2 * half : ub;
    int sr   = sa - sb;
    r.diff = 8'((ua - ub) & mask);
    r.bout = (ua < ub);
    r.ovf  = (sr < -half) || (sr > half - 1);
    return r;
  endfunction

  function automatic void chk(string n, logic [63:0] act, logic [63:0] want);
    chk_t c;
    c.name = n; c.act = act; c.want = want;
    chk_q.push_back(c);
  endfunction

  // Monitor: sole owner of the counters; pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    int   pend;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act !== c.want) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.want);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        wait_cyc[i] = 0;
        n_cmp++;
        if (exp_q[i].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done w%0d: got done=1 expected no pending op", wd[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (diff_v[i] !== e.diff) begin
            n_fail++;
            $display("FAIL diff w%0d: got %0h expected %0h", wd[i], diff_v[i], e.diff);
          end
          n_cmp++;
          if (bout_v[i] !== e.bout) begin
            n_fail++;
            $display("FAIL bout w%0d: got %0b expected %0b", wd[i], bout_v[i], e.bout);
          end
          n_cmp++;
          if (ovf_v[i] !== e.ovf) begin
            n_fail++;
            $display("FAIL ovf w%0d: got %0b expected %0b", wd[i], ovf_v[i], e.ovf);
          end
        end
      end else if (exp_q[i].size() > 0) begin
        wait_cyc[i]++;
        if (wait_cyc[i] > 3 * wd[i] + 20) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_timeout w%0d: got no done after %0d cycles expected done", wd[i], wait_cyc[i]);
          void'(exp_q[i].pop_front());
          wait_cyc[i] = 0;
        end
      end else begin
        wait_cyc[i] = 0;
      end
    end
    if (end_req && !end_ack) begin
      pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      n_cmp++;
      if (pend != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d pending results expected 0", pend);
      end
      end_ack = 1;
    end
  end

  task automatic set_start(int idx, logic v);
    case (idx)
      0:       if4.start = v;
      1:       if1.start = v;
      default: if8.start = v;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(int idx, logic [7:0] a, logic [7:0] b, bit hold);
    int guard;
    guard = 0;
    while (busy_v[idx] && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) chk("idle_wait", 64'(busy_v[idx]), 64'd0);
    case (idx)
      0:       begin if4.a = a[3:0]; if4.b = b[3:0]; end
      1:       begin if1.a = a[0];   if1.b = b[0];   end
      default: begin if8.a = a;      if8.b = b;      end
    endcase
    set_start(idx, 1'b1);
    exp_q[idx].push_back(ref_sub(wd[idx], a, b));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) set_start(idx, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int nb, nd, dpos, prev, k;
    rst = 1'b1;
    if4.start = 0; if4.a = '0; if4.b = '0;
    if1.start = 0; if1.a = '0; if1.b = '0;
    if8.start = 0; if8.a = '0; if8.b = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(if4.busy), 64'd0);
    chk("rst_done", 64'(if4.done), 64'd0);
    chk("rst_diff", 64'(if4.diff), 64'd0);
    chk("rst_bout", 64'(if4.bout), 64'd0);
    chk("rst_ovf",  64'(if4.ovf),  64'd0);
    chk("rst_diff8", 64'(if8.diff), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 9 - 3 = 6; as signed this is -7 - 3, which overflows 4 bits.
    issue(0, 8'd9, 8'd3, 0);
    nb = 0; nd = 0; dpos = 0;
    for (int j = 1; j <= 12; j++) begin
      if (if4.busy) nb++;
      if (if4.done) begin nd++; dpos = j; end
      @(negedge clk);
    end
    chk("busy_cycles", 64'(nb), 64'd5);
    chk("done_pulses", 64'(nd), 64'd1);
    chk("done_pos",    64'(dpos), 64'd5);

    issue(0, 8'd3, 8'd9, 0);
    issue(0, 8'd0, 8'd0, 0);
    issue(0, 8'h8, 8'h1, 0);
    issue(0, 8'h7, 8'hF, 0);

    // Second start during RUN must be ignored.
    issue(0, 8'd9, 8'd3, 0);
    if4.a = 4'd1; if4.b = 4'd1; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignored_start_busy", 64'(if4.busy), 64'd0);

    // Asynchronous reset between E2 and E3 aborts and clears results.
    issue(0, 8'd10, 8'd4, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q[0].delete();
    #1;
    chk("mid_rst_busy", 64'(if4.busy), 64'd0);
    chk("mid_rst_done", 64'(if4.done), 64'd0);
    chk("mid_rst_diff", 64'(if4.diff), 64'd0);
    chk("mid_rst_bout", 64'(if4.bout), 64'd0);
    chk("mid_rst_ovf",  64'(if4.ovf),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_diff", 64'(if4.diff), 64'd0);
    issue(0, 8'd5, 8'd2, 0);

    // Exhaustive WIDTH=4 with start held high: accepts every WIDTH+2 cycles.
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        issue(0, 8'(i), 8'(j), 1);
        if (prev >= 0) chk("accept_spacing", 64'(acc_cyc - prev), 64'd6);
        prev = acc_cyc;
      end
    end
    if4.start = 1'b0;

    for (int n = 0; n < 40; n++)
      issue(1, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    if1.start = 1'b0;

    for (int n = 0; n < 100; n++)
      issue(2, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    if8.start = 1'b0;

    k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    end_req = 1;
    for (int j = 0; j < 5 && !end_ack; j++) @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
